// File: rtl/ic_axi_sram_bridge.sv
// rtl/ic_axi_sram_bridge.sv - single-outstanding AXI4-Lite slave onto a synchronous SRAM window
module ic_axi_sram_bridge #(
    parameter logic [31:0] MEM_BASE = 32'h0000_0000,
    parameter logic [31:0] MEM_SIZE = 32'h0000_1000
) (
    input  logic        s0_aclk,
    input  logic        s0_aresetn,
    input  logic        s0_awvalid,
    output logic        s0_awready,
    input  logic [31:0] s0_awaddr,
    input  logic [2:0]  s0_awprot,
    input  logic        s0_wvalid,
    output logic        s0_wready,
    input  logic [31:0] s0_wdata,
    input  logic [3:0]  s0_wstrb,
    output logic        s0_bvalid,
    input  logic        s0_bready,
    output logic [1:0]  s0_bresp,
    input  logic        s0_arvalid,
    output logic        s0_arready,
    input  logic [31:0] s0_araddr,
    input  logic [2:0]  s0_arprot,
    output logic        s0_rvalid,
    input  logic        s0_rready,
    output logic [1:0]  s0_rresp,
    output logic [31:0] s0_rdata,
    output logic        sram_cen,
    output logic        sram_wen,
    output logic [3:0]  sram_strb,
    output logic [29:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata
);
    typedef enum logic [2:0] {IDLE, WR_MEM, RD_MEM, WR_RSP, RD_RSP} state_t;

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_DECERR = 2'b11;
    localparam logic [32:0] LIMIT       = {1'b0, MEM_BASE} + {1'b0, MEM_SIZE};
    localparam logic [30:0] BASE_W      = {1'b0, MEM_BASE[31:2]};
    localparam logic [30:0] LIMIT_W     = LIMIT[32:2];

    state_t      state_q, state_d;
    logic        aw_held_q, aw_held_d;
    logic        w_held_q, w_held_d;
    logic        last_wr_q, last_wr_d;
    logic        rd_first_q, rd_first_d;
    logic [1:0]  resp_q, resp_d;
    logic [31:0] rdata_q, rdata_d;
    logic [29:0] awaddr_q, araddr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;

    logic        aw_rdy, w_rdy, ar_rdy;
    logic        wr_ok, rd_ok, wr_pending;
    logic [31:0] rd_now;
    logic        unused_bits;

    assign unused_bits = ^{s0_awprot, s0_arprot, s0_awaddr[1:0], s0_araddr[1:0]};

    // Range checks work on word addresses, so the byte offset bits never matter.
    assign wr_ok      = ({1'b0, awaddr_q} >= BASE_W) && ({1'b0, awaddr_q} < LIMIT_W);
    assign rd_ok      = ({1'b0, araddr_q} >= BASE_W) && ({1'b0, araddr_q} < LIMIT_W);
    assign wr_pending = s0_awvalid | s0_wvalid | aw_held_q | w_held_q;
    assign rd_now     = rd_ok ? sram_rdata : 32'h0;

    always_ff @(posedge s0_aclk or negedge s0_aresetn) begin
        if (!s0_aresetn) begin
            state_q    <= IDLE;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            last_wr_q  <= 1'b1;
            rd_first_q <= 1'b0;
            resp_q     <= RESP_OKAY;
            rdata_q    <= 32'h0;
            awaddr_q   <= 30'h0;
            araddr_q   <= 30'h0;
            wdata_q    <= 32'h0;
            wstrb_q    <= 4'h0;
        end else begin
            state_q    <= state_d;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            last_wr_q  <= last_wr_d;
            rd_first_q <= rd_first_d;
            resp_q     <= resp_d;
            rdata_q    <= rdata_d;
            if (s0_awvalid && aw_rdy) awaddr_q <= s0_awaddr[31:2];
            if (s0_wvalid && w_rdy) begin
                wdata_q <= s0_wdata;
                wstrb_q <= s0_wstrb;
            end
            if (s0_arvalid && ar_rdy) araddr_q <= s0_araddr[31:2];
        end
    end

    always_comb begin
        state_d    = state_q;
        aw_held_d  = aw_held_q;
        w_held_d   = w_held_q;
        last_wr_d  = last_wr_q;
        rd_first_d = 1'b0;
        resp_d     = resp_q;
        rdata_d    = rdata_q;
        aw_rdy     = 1'b0;
        w_rdy      = 1'b0;
        ar_rdy     = 1'b0;
        sram_cen   = 1'b0;
        sram_wen   = 1'b0;
        sram_strb  = 4'h0;
        sram_addr  = 30'h0;
        sram_wdata = 32'h0;
        case (state_q)
            IDLE: begin
                // Reads win only after a write grant or when no write is in sight.
                if (s0_arvalid && (last_wr_q || !wr_pending)) begin
                    ar_rdy    = 1'b1;
                    state_d   = RD_MEM;
                    last_wr_d = 1'b0;
                end else begin
                    aw_rdy    = !aw_held_q;
                    w_rdy     = !w_held_q;
                    aw_held_d = aw_held_q | s0_awvalid;
                    w_held_d  = w_held_q | s0_wvalid;
                    if (aw_held_d && w_held_d) begin
                        state_d   = WR_MEM;
                        last_wr_d = 1'b1;
                    end
                end
            end
            WR_MEM: begin
                if (wr_ok) begin
                    sram_cen   = 1'b1;
                    sram_wen   = 1'b1;
                    sram_strb  = wstrb_q;
                    sram_addr  = awaddr_q - MEM_BASE[31:2];
                    sram_wdata = wdata_q;
                end
                aw_held_d = 1'b0;
                w_held_d  = 1'b0;
                resp_d    = wr_ok ? RESP_OKAY : RESP_DECERR;
                state_d   = WR_RSP;
            end
            RD_MEM: begin
                if (rd_ok) begin
                    sram_cen  = 1'b1;
                    sram_addr = araddr_q - MEM_BASE[31:2];
                end
                resp_d     = rd_ok ? RESP_OKAY : RESP_DECERR;
                rd_first_d = 1'b1;
                state_d    = RD_RSP;
            end
            WR_RSP: begin
                if (s0_bready) state_d = IDLE;
            end
            RD_RSP: begin
                // SRAM data is only valid in the first response cycle; keep a copy.
                if (rd_first_q) rdata_d = rd_now;
                if (s0_rready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign s0_awready = aw_rdy & s0_aresetn;
    assign s0_wready  = w_rdy & s0_aresetn;
    assign s0_arready = ar_rdy & s0_aresetn;
    assign s0_bvalid  = (state_q == WR_RSP);
    assign s0_bresp   = (state_q == WR_RSP) ? resp_q : RESP_OKAY;
    assign s0_rvalid  = (state_q == RD_RSP);
    assign s0_rresp   = (state_q == RD_RSP) ? resp_q : RESP_OKAY;
    assign s0_rdata   = (state_q != RD_RSP) ? 32'h0 : (rd_first_q ? rd_now : rdata_q);

endmodule

// File: tb/tb_ic_axi_sram_bridge.sv
// tb/tb_ic_axi_sram_bridge.sv - randomized self-checking bench for ic_axi_sram_bridge
module tb_ic_axi_sram_bridge;
    localparam logic [31:0] MEM_BASE = 32'h0000_0000;
    localparam logic [31:0] MEM_SIZE = 32'h0000_1000;
    localparam int WORDS = 1024;

    logic        clk = 1'b0;
    logic        s0_aresetn;
    logic        s0_awvalid, s0_awready, s0_wvalid, s0_wready;
    logic [31:0] s0_awaddr, s0_wdata, s0_araddr, s0_rdata;
    logic [2:0]  s0_awprot, s0_arprot;
    logic [3:0]  s0_wstrb;
    logic        s0_bvalid, s0_bready, s0_arvalid, s0_arready, s0_rvalid, s0_rready;
    logic [1:0]  s0_bresp, s0_rresp;
    logic        sram_cen, sram_wen;
    logic [3:0]  sram_strb;
    logic [29:0] sram_addr;
    logic [31:0] sram_wdata, sram_rdata;

    logic [31:0] ref_mem [WORDS];
    logic [31:0] sram_mem [WORDS];
    logic        load_req;
    int          cen_count = 0;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    ic_axi_sram_bridge #(.MEM_BASE(MEM_BASE), .MEM_SIZE(MEM_SIZE)) dut (
        .s0_aclk(clk), .s0_aresetn(s0_aresetn),
        .s0_awvalid(s0_awvalid), .s0_awready(s0_awready), .s0_awaddr(s0_awaddr), .s0_awprot(s0_awprot),
        .s0_wvalid(s0_wvalid), .s0_wready(s0_wready), .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb),
        .s0_bvalid(s0_bvalid), .s0_bready(s0_bready), .s0_bresp(s0_bresp),
        .s0_arvalid(s0_arvalid), .s0_arready(s0_arready), .s0_araddr(s0_araddr), .s0_arprot(s0_arprot),
        .s0_rvalid(s0_rvalid), .s0_rready(s0_rready), .s0_rresp(s0_rresp), .s0_rdata(s0_rdata),
        .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_strb(sram_strb), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    // Synchronous SRAM: read data appears after the edge that samples sram_cen, junk otherwise.
    always @(posedge clk) begin
        logic [31:0] m;
        if (load_req)
            for (int i = 0; i < WORDS; i++) sram_mem[i] <= ref_mem[i];
        if (sram_cen) cen_count <= cen_count + 1;
        if (sram_cen && sram_wen && sram_addr < WORDS) begin
            m = sram_mem[sram_addr];
            for (int b = 0; b < 4; b++)
                if (sram_strb[b]) m[8*b +: 8] = sram_wdata[8*b +: 8];
            sram_mem[sram_addr] <= m;
        end
        if (sram_cen && !sram_wen && sram_addr < WORDS) sram_rdata <= sram_mem[sram_addr];
        else sram_rdata <= $urandom;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit in_win(input logic [31:0] a);
        longint w;
        w = longint'({a[31:2], 2'b00});
        return (w >= longint'(MEM_BASE)) && (w < longint'(MEM_BASE) + longint'(MEM_SIZE));
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - MEM_BASE) >> 2);
    endfunction

    function automatic logic outs_any();
        return |{s0_awready, s0_wready, s0_arready, s0_bvalid, s0_bresp, s0_rvalid, s0_rresp,
                 s0_rdata, sram_cen, sram_wen, sram_strb, sram_addr, sram_wdata};
    endfunction

    task automatic ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        for (int b = 0; b < 4; b++)
            if (s[b]) ref_mem[widx(a)][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic do_reset();
        s0_aresetn = 1'b0;
        repeat (2) @(posedge clk);
        #1 s0_aresetn = 1'b1;
    endtask

    // lead > 0: W is offered that many cycles before AW; lead < 0: AW first.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int lead, input int bdly);
        int  t, aws, ws, c0;
        bit  awd, wd, ok;
        ok  = in_win(a);
        aws = (lead > 0) ? lead : 0;
        ws  = (lead < 0) ? -lead : 0;
        awd = 0; wd = 0; t = 0;
        c0  = cen_count;
        s0_awaddr = a; s0_wdata = d; s0_wstrb = s; s0_awprot = 3'($urandom);
        while (!(awd && wd) && t < 40) begin
            s0_awvalid = !awd && (t >= aws);
            s0_wvalid  = !wd && (t >= ws);
            @(negedge clk);
            if (s0_awvalid && s0_awready) awd = 1;
            if (s0_wvalid && s0_wready) wd = 1;
            @(posedge clk); #1; t++;
        end
        s0_awvalid = 0; s0_wvalid = 0;
        check("wr_handshake", {awd, wd}, 2'b11);
        @(negedge clk);
        check("wr_cen", sram_cen, ok);
        if (ok) begin
            check("wr_wen", sram_wen, 1);
            check("wr_addr", sram_addr, widx(a));
            check("wr_wdata", sram_wdata, d);
            check("wr_strb", sram_strb, s);
        end
        check("wr_busy_ready", {s0_awready, s0_wready, s0_arready}, 0);
        @(posedge clk); #1;
        for (int i = 0; i <= bdly; i++) begin
            s0_bready = (i == bdly);
            @(negedge clk);
            check("wr_bvalid", s0_bvalid, 1);
            check("wr_bresp", s0_bresp, ok ? 2'b00 : 2'b11);
            @(posedge clk); #1;
        end
        s0_bready = 0;
        check("wr_bvalid_drop", s0_bvalid, 0);
        check("wr_cen_count", cen_count - c0, ok ? 1 : 0);
        if (ok) ref_write(a, d, s);
    endtask

    task automatic do_read(input logic [31:0] a, input int rdly, input bit abort);
        int          t, c0;
        bit          ard, ok;
        logic [31:0] exp;
        ok  = in_win(a);
        exp = 32'h0;
        if (ok) exp = ref_mem[widx(a)];
        ard = 0; t = 0;
        c0  = cen_count;
        s0_araddr = a; s0_arprot = 3'($urandom); s0_arvalid = 1;
        while (!ard && t < 40) begin
            @(negedge clk);
            if (s0_arready) begin
                ard = 1;
                check("rd_grant_excl", {s0_awready, s0_wready}, 0);
            end
            @(posedge clk); #1; t++;
        end
        s0_arvalid = 0;
        check("rd_handshake", ard, 1);
        @(negedge clk);
        check("rd_cen", sram_cen, ok);
        if (ok) begin
            check("rd_wen", sram_wen, 0);
            check("rd_strb", sram_strb, 0);
            check("rd_addr", sram_addr, widx(a));
        end
        @(posedge clk); #1;
        if (abort) begin
            @(negedge clk);
            check("abort_rvalid_pre", s0_rvalid, 1);
            @(posedge clk); #1;
            c0 = cen_count;
            s0_aresetn = 0;
            #1;
            check("abort_rvalid", s0_rvalid, 0);
            check("abort_outs_zero", outs_any(), 0);
            repeat (2) @(posedge clk);
            #1;
            check("abort_no_cen", cen_count - c0, 0);
            s0_aresetn = 1;
            return;
        end
        for (int i = 0; i <= rdly; i++) begin
            s0_rready = (i == rdly);
            @(negedge clk);
            check("rd_rvalid", s0_rvalid, 1);
            check("rd_rresp", s0_rresp, ok ? 2'b00 : 2'b11);
            check("rd_rdata", s0_rdata, exp);
            @(posedge clk); #1;
        end
        s0_rready = 0;
        check("rd_rvalid_drop", s0_rvalid, 0);
        check("rd_cen_count", cen_count - c0, ok ? 1 : 0);
    endtask

    task automatic round_robin();
        int          g [4];
        int          n, t;
        logic [31:0] d;
        d = $urandom;
        n = 0; t = 0;
        s0_araddr = 32'h44; s0_awaddr = 32'h40; s0_wdata = d; s0_wstrb = 4'hF;
        s0_arvalid = 1; s0_awvalid = 1; s0_wvalid = 1; s0_bready = 1; s0_rready = 1;
        while (n < 4 && t < 60) begin
            @(negedge clk);
            if (s0_arready) begin
                check("rr_read_excl", {s0_awready, s0_wready}, 0);
                g[n] = 0; n++;
            end else if (s0_awready && s0_wready) begin
                g[n] = 1; n++;
            end
            @(posedge clk); #1; t++;
        end
        s0_arvalid = 0; s0_awvalid = 0; s0_wvalid = 0;
        repeat (4) @(posedge clk);
        #1;
        s0_bready = 0; s0_rready = 0;
        check("rr_grants", n, 4);
        for (int i = 0; i < n; i++) check($sformatf("rr_grant%0d", i), g[i], i % 2);
        ref_write(32'h40, d, 4'hF);
    endtask

    initial begin
        logic [31:0] a, d;
        s0_aresetn = 0;
        s0_awvalid = 0; s0_wvalid = 0; s0_arvalid = 0; s0_bready = 0; s0_rready = 0;
        s0_awaddr = 0; s0_wdata = 0; s0_wstrb = 0; s0_araddr = 0; s0_awprot = 0; s0_arprot = 0;
        for (int i = 0; i < WORDS; i++) ref_mem[i] = $urandom;
        ref_mem[4] = 32'hCAFE_F00D;
        load_req = 1;
        @(posedge clk); #1;
        load_req = 0;
        s0_awvalid = 1; s0_wvalid = 1; s0_arvalid = 1;
        #1 check("reset_outs_zero", outs_any(), 0);
        s0_awvalid = 0; s0_wvalid = 0; s0_arvalid = 0;
        @(posedge clk); #1 s0_aresetn = 1;

        do_read(32'h10, 3, 0);
        do_read(32'h1000, 1, 0);
        do_write(32'h2000, 32'h1234_5678, 4'hF, 0, 0);
        do_write(32'h10, 32'hDEAD_BEEF, 4'hF, 0, 0);
        do_read(32'h10, 0, 0);
        do_write(32'h20, 32'hA5A5_5A5A, 4'hF, 2, 1);
        do_write(32'h24, 32'h0BAD_F00D, 4'h5, -2, 0);
        do_read(32'h24, 2, 0);

        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 5) == 0) a = 32'h1000 + ($urandom & 32'h0000_FFFF);
            else a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            d = $urandom;
            if ($urandom_range(0, 1) == 0)
                do_write(a, d, 4'($urandom), $urandom_range(0, 4) - 2, $urandom_range(0, 2));
            else
                do_read(a, $urandom_range(0, 3), 0);
        end

        do_reset();
        round_robin();
        do_read(32'h40, 0, 0);

        do_read(32'h10, 0, 1);
        do_read(32'h24, 1, 0);
        do_write(32'h30, 32'h7777_8888, 4'hC, 1, 0);
        do_read(32'h30, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ic_axi_sram_bridge.md
IC_AXI_SRAM_BRIDGE -- requirements
Module: ic_axi_sram_bridge

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  MEM_BASE  32'h0000_0000  byte base address of the SRAM window
  MEM_SIZE  32'h0000_1000  window size in bytes (multiple of 4)
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  s0_aclk     in   1   sole clock; all state on rising edge
  s0_aresetn  in   1   reset; asynchronous assert, active-low
  s0_awvalid  in   1   write address valid
  s0_awready  out  1   write address ready
  s0_awaddr   in   32  write byte address
  s0_awprot   in   3   ignored
  s0_wvalid   in   1   write data valid
  s0_wready   out  1   write data ready
  s0_wdata    in   32  write data
  s0_wstrb    in   4   byte strobes
  s0_bvalid   out  1   write response valid
  s0_bready   in   1   write response ready
  s0_bresp    out  2   2'b00 OKAY, 2'b11 DECERR
  s0_arvalid  in   1   read address valid
  s0_arready  out  1   read address ready
  s0_araddr   in   32  read byte address
  s0_arprot   in   3   ignored
  s0_rvalid   out  1   read data valid
  s0_rready   in   1   read data ready
  s0_rresp    out  2   2'b00 OKAY, 2'b11 DECERR
  s0_rdata    out  32  read data
  sram_cen    out  1   SRAM access strobe, one cycle per access
  sram_wen    out  1   1 = write, 0 = read; valid with sram_cen
  sram_strb   out  4   byte write enables
  sram_addr   out  30  word address = (addr - MEM_BASE) >> 2
  sram_wdata  out  32  write data
  sram_rdata  in   32  read data, valid the cycle after a read sram_cen

Function
REQ-003 The FSM SHALL have states IDLE, WR_MEM, RD_MEM, WR_RSP, RD_RSP; one transaction in flight at a time.
REQ-004 An address SHALL be in range iff MEM_BASE <= addr < MEM_BASE+MEM_SIZE; addr[1:0] ignored.
REQ-005 In IDLE, a read SHALL be granted (s0_arready=1, awready=wready=0 that cycle) when s0_arvalid and (last grant was write, or no AW/W valid or buffered).
REQ-006 Otherwise in IDLE: s0_awready = !aw_held, s0_wready = !w_held; AW and W SHALL be buffered independently, in either order or together.
REQ-007 Outside IDLE all of s0_awready, s0_wready, s0_arready SHALL be 0.
REQ-008 When aw_held and w_held are both set (including the completing handshake cycle), next state SHALL be WR_MEM; last grant := write.
REQ-009 On read handshake, address SHALL be captured, next state RD_MEM; last grant := read.
REQ-010 WR_MEM: if in range, sram_cen=1, sram_wen=1, sram_strb/addr/wdata from buffers; else no SRAM access; next WR_RSP; aw_held/w_held cleared.
REQ-011 RD_MEM: if in range, sram_cen=1, sram_wen=0, sram_strb=0; next RD_RSP; s0_rdata SHALL register sram_rdata on entry to RD_RSP, or 32'h0 if out of range.
REQ-012 WR_RSP: s0_bvalid=1, bresp=OKAY/DECERR per range, held stable until s0_bready; then IDLE.
REQ-013 RD_RSP: s0_rvalid=1, rresp, rdata held stable until s0_rready; then IDLE.
REQ-014 Latency: handshake in cycle N -> SRAM access N+1 -> bvalid/rvalid N+2; back-to-back throughput 1 transaction per 3 cycles minimum.
REQ-015 sram_cen SHALL never assert outside WR_MEM/RD_MEM or for an out-of-range address.
REQ-016 Simultaneous arvalid and awvalid/wvalid with equal priority SHALL alternate grants (round-robin).

Reset
REQ-017 s0_aresetn low SHALL immediately force state IDLE, clear aw_held/w_held, set last grant := write, and drive every output to 0 (rdata, resp 0).
REQ-018 Reset mid-transaction SHALL abandon it without completing any SRAM access or response.

Verification
REQ-019 Write 0x10 data 0xDEADBEEF strb 4'hF, AW/W same cycle -> sram_cen/wen at N+1 addr 30'h4; bvalid N+2 bresp 00.
REQ-020 W two cycles before AW to 0x20 -> wready then awready, single SRAM write addr 30'h8 after AW.
REQ-021 Read 0x10, sram_rdata=0xCAFEF00D -> rvalid N+2, rdata 0xCAFEF00D, rresp 00; rready delayed 3 cycles -> outputs stable.
REQ-022 Read 0x1000 (out of range) -> no sram_cen, rresp 2'b11, rdata 0; write 0x2000 -> bresp 2'b11.
REQ-023 AR and AW+W valid continuously -> grants alternate read, write, read after reset.
REQ-024 s0_aresetn low during RD_RSP -> rvalid 0 immediately; new read after release completes normally.
